fpga_ps_loader: RTL and testbench

Passive-serial configuration engine for the ACEX1K. It sits downstream of the Z80 port decode, which delivers config bytes as a one-cycle write strobe plus data. It drives nCONFIG, DCLK and DATA0, and it sequences the full configuration: nCONFIG pulse, nSTATUS handshake, byte shifting, CONF_DONE detection, init clocks and INIT_DONE wait. It reports ready, busy, done and error flags back to the Z80 status port.

---
 rtl/fpga_ps_loader_pkg.sv | 26 ++
 rtl/fpga_ps_loader_shifter.sv | 74 +++++++
 rtl/fpga_ps_loader.sv | 211 +++++++++++++++++++++
 tb/tb_fpga_ps_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_ps_loader_pkg.sv
// Shared definitions for the ACEX1K passive-serial loader: state encoding,
// default timing parameters and a counter-width helper.
package fpga_ps_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_NCFG      = 4'd1,
    ST_WAIT_ST   = 4'd2,
    ST_READY     = 4'd3,
    ST_SHIFT     = 4'd4,
    ST_INITCLK   = 4'd5,
    ST_WAIT_INIT = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } ps_state_t;

  localparam int DEF_NCFG_CYCLES = 16;
  localparam int DEF_DCLK_DIV    = 2;
  localparam int DEF_ST_TIMEOUT  = 4096;
  localparam int DEF_INIT_CLKS   = 10;

  function automatic int cnt_w(input int val);
    return $clog2(val) + 1;
  endfunction

endpackage

// File: rtl/fpga_ps_loader_shifter.sv
// Byte latch, DCLK divider and bit counter: shifts one byte LSB first,
// DATA0 changing only while DCLK is low.
module fpga_ps_loader_shifter
  import fpga_ps_loader_pkg::*;
#(
  parameter int DCLK_DIV = DEF_DCLK_DIV
) (
  input  logic       clkin,
  input  logic       coldres_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       abort_i,
  output logic       dclk_o,
  output logic       data0_o,
  output logic       last_edge_o
);

  localparam int DW = cnt_w(DCLK_DIV);

  logic [7:0]    byte_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic          active_q;
  logic          dclk_q;
  logic          data0_q;
  logic          phase_end;

  assign phase_end   = (div_q == DW'(DCLK_DIV - 1));
  // High during the final cycle of bit 7's high phase, so the FSM moves on
  // on the same edge that drops DCLK.
  assign last_edge_o = active_q && dclk_q && phase_end && (bit_q == 3'd7);
  assign dclk_o      = dclk_q;
  assign data0_o     = data0_q;

  always_ff @(posedge clkin) begin
    if (!coldres_n) begin
      byte_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      dclk_q   <= 1'b0;
      data0_q  <= 1'b0;
    end else if (abort_i) begin
      active_q <= 1'b0;
      dclk_q   <= 1'b0;
      div_q    <= '0;
    end else if (load_i) begin
      byte_q   <= byte_i;
      data0_q  <= byte_i[0];
      dclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (phase_end) begin
        div_q <= '0;
        if (!dclk_q) begin
          dclk_q <= 1'b1;
        end else begin
          dclk_q <= 1'b0;
          if (bit_q == 3'd7) begin
            active_q <= 1'b0;
          end else begin
            bit_q   <= bit_q + 3'd1;
            data0_q <= byte_q[bit_q + 3'd1];
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_ps_loader.sv
// Passive-serial configuration sequencer for the ACEX1K: nCONFIG pulse,
// nSTATUS handshake, byte shifting, init clocks and INIT_DONE wait.
module fpga_ps_loader
  import fpga_ps_loader_pkg::*;
#(
  parameter int NCFG_CYCLES = DEF_NCFG_CYCLES,
  parameter int DCLK_DIV    = DEF_DCLK_DIV,
  parameter int ST_TIMEOUT  = DEF_ST_TIMEOUT,
  parameter int INIT_CLKS   = DEF_INIT_CLKS
) (
  input  logic       clkin,
  input  logic       coldres_n,
  input  logic       cfg_start,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  input  logic       status_n,
  input  logic       conf_done,
  input  logic       init_done,
  output logic       config_n,
  output logic       dclk,
  output logic       data0,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       overrun
);

  localparam int NW = cnt_w(NCFG_CYCLES);
  localparam int TW = cnt_w(ST_TIMEOUT);
  localparam int IW = cnt_w(INIT_CLKS);
  localparam int DW = cnt_w(DCLK_DIV);

  ps_state_t     state_q;
  logic [NW-1:0] ncfg_cnt_q;
  logic [TW-1:0] st_cnt_q;
  logic [IW-1:0] init_cnt_q;
  logic [DW-1:0] idiv_q;
  logic          st_s1_q, st_s2_q, cd_s1_q, cd_s2_q, id_s1_q, id_s2_q;
  logic          st_seen_q, config_n_q, ready_q, busy_q, done_q, error_q, overrun_q;
  logic          idclk_q, id0_q;
  logic          sh_load, sh_abort, sh_dclk, sh_data0, sh_last;

  assign sh_load  = (state_q == ST_READY) && wr_stb && !cfg_start && st_s2_q;
  assign sh_abort = cfg_start || ((state_q == ST_SHIFT) && !st_s2_q);

  fpga_ps_loader_shifter #(.DCLK_DIV(DCLK_DIV)) u_shifter (
    .clkin       (clkin),
    .coldres_n   (coldres_n),
    .load_i      (sh_load),
    .byte_i      (wr_data),
    .abort_i     (sh_abort),
    .dclk_o      (sh_dclk),
    .data0_o     (sh_data0),
    .last_edge_o (sh_last)
  );

  always_ff @(posedge clkin) begin
    if (!coldres_n) begin
      st_s1_q <= 1'b1;
      st_s2_q <= 1'b1;
      cd_s1_q <= 1'b0;
      cd_s2_q <= 1'b0;
      id_s1_q <= 1'b0;
      id_s2_q <= 1'b0;
    end else begin
      st_s1_q <= status_n;
      st_s2_q <= st_s1_q;
      cd_s1_q <= conf_done;
      cd_s2_q <= cd_s1_q;
      id_s1_q <= init_done;
      id_s2_q <= id_s1_q;
    end
  end

  always_ff @(posedge clkin) begin
    if (!coldres_n) begin
      state_q    <= ST_IDLE;
      ncfg_cnt_q <= '0;
      st_cnt_q   <= '0;
      init_cnt_q <= '0;
      idiv_q     <= '0;
      st_seen_q  <= 1'b0;
      config_n_q <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      overrun_q  <= 1'b0;
      idclk_q    <= 1'b0;
      id0_q      <= 1'b0;
    end else if (cfg_start) begin
      state_q    <= ST_NCFG;
      ncfg_cnt_q <= '0;
      st_seen_q  <= 1'b0;
      config_n_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      overrun_q  <= 1'b0;
      idclk_q    <= 1'b0;
      id0_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_NCFG: begin
          if (!st_s2_q) st_seen_q <= 1'b1;
          if (ncfg_cnt_q == NW'(NCFG_CYCLES - 1)) begin
            config_n_q <= 1'b1;
            // The FPGA must have acknowledged the pulse by dropping nSTATUS.
            if (st_seen_q || !st_s2_q) begin
              state_q  <= ST_WAIT_ST;
              st_cnt_q <= '0;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            ncfg_cnt_q <= ncfg_cnt_q + 1'b1;
          end
        end
        ST_WAIT_ST: begin
          if (st_s2_q) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end else if (st_cnt_q == TW'(ST_TIMEOUT - 1)) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            st_cnt_q <= st_cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (!st_s2_q) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end else if (wr_stb) begin
            state_q <= ST_SHIFT;
            ready_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (wr_stb) overrun_q <= 1'b1;
          if (!st_s2_q) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (sh_last) begin
            if (cd_s2_q) begin
              state_q    <= ST_INITCLK;
              init_cnt_q <= '0;
              idiv_q     <= '0;
              idclk_q    <= 1'b0;
              id0_q      <= 1'b1;
            end else begin
              state_q <= ST_READY;
              ready_q <= 1'b1;
            end
          end
        end
        ST_INITCLK: begin
          if (!st_s2_q) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            idclk_q <= 1'b0;
            id0_q   <= 1'b0;
          end else if (idiv_q == DW'(DCLK_DIV - 1)) begin
            idiv_q <= '0;
            if (!idclk_q) begin
              idclk_q <= 1'b1;
            end else begin
              idclk_q <= 1'b0;
              if (init_cnt_q == IW'(INIT_CLKS - 1)) begin
                state_q <= ST_WAIT_INIT;
                id0_q   <= 1'b0;
              end else begin
                init_cnt_q <= init_cnt_q + 1'b1;
              end
            end
          end else begin
            idiv_q <= idiv_q + 1'b1;
          end
        end
        ST_WAIT_INIT: begin
          if (id_s2_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign config_n = config_n_q;
  assign dclk     = sh_dclk | idclk_q;
  assign data0    = sh_data0 | id0_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fpga_ps_loader.sv
// Self-checking bench for fpga_ps_loader with a simple FPGA-side model.
module tb_fpga_ps_loader;

  localparam int NCFG  = 16;
  localparam int DIV   = 2;
  localparam int INITC = 10;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic       coldres_n, cfg_start, wr_stb;
  logic [7:0] wr_data;
  logic       status_n, conf_done, init_done;
  logic       config_n, dclk, data0, ready, busy, done, error, overrun;
  logic       t_config_n, t_dclk, t_data0, t_ready, t_busy, t_done, t_error, t_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  fpga_ps_loader dut (
    .clkin(clkin), .coldres_n(coldres_n), .cfg_start(cfg_start), .wr_stb(wr_stb),
    .wr_data(wr_data), .status_n(status_n), .conf_done(conf_done), .init_done(init_done),
    .config_n(config_n), .dclk(dclk), .data0(data0), .ready(ready), .busy(busy),
    .done(done), .error(error), .overrun(overrun)
  );

  fpga_ps_loader #(.ST_TIMEOUT(8)) dut_t (
    .clkin(clkin), .coldres_n(coldres_n), .cfg_start(cfg_start), .wr_stb(wr_stb),
    .wr_data(wr_data), .status_n(status_n), .conf_done(conf_done), .init_done(init_done),
    .config_n(t_config_n), .dclk(t_dclk), .data0(t_data0), .ready(t_ready), .busy(t_busy),
    .done(t_done), .error(t_error), .overrun(t_overrun)
  );

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Pulse cfg_start and play the FPGA: nSTATUS low early in the nCONFIG pulse,
  // released during cycle 'rel' after nCONFIG rises.
  task automatic bring_up(input int rel);
    int low;
    int n;
    status_n = 1'b1; conf_done = 1'b0; init_done = 1'b0;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    low = 0;
    while (config_n === 1'b0 && low < 100) begin
      low++;
      if (low == 3) status_n = 1'b0;
      tick();
    end
    n_checks++;
    if (low !== NCFG) begin
      n_fail++; $display("FAIL ncfg_low_cycles: got %0d expected %0d", low, NCFG);
    end
    n = 0;
    while (n < rel + 40) begin
      n++;
      if (n == rel) status_n = 1'b1;
      tick();
      if (ready === 1'b1) break;
    end
    n_checks++;
    if (n !== rel + 2) begin
      n_fail++; $display("FAIL ready_latency: got %0d expected %0d", n, rel + 2);
    end
    n_checks++;
    if ({busy, error} !== 2'b10) begin
      n_fail++; $display("FAIL ready_flags busy/error: got %b expected 10", {busy, error});
    end
  endtask

  // Send one byte and check the DCLK/DATA0 trace against the LSB-first bit timing.
  task automatic send_byte(input logic [7:0] b, input int ovr_at, input int conf_at,
                           input bit expect_init);
    logic [1:0] exp;
    int rises;
    logic prev;
    wr_data = b; wr_stb = 1'b1; tick(); wr_stb = 1'b0; wr_data = 8'($urandom);
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 16 * DIV; k++) begin
      exp = {((k % (2 * DIV)) >= DIV), b[k / (2 * DIV)]};
      n_checks++;
      if ({dclk, data0} !== exp) begin
        n_fail++; $display("FAIL shift_trace byte %02h cycle %0d: dclk,data0 got %b expected %b", b, k, {dclk, data0}, exp);
      end
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_during_shift cycle %0d: got %b expected 0", k, ready);
      end
      if (dclk === 1'b1 && prev === 1'b0) rises++;
      prev = dclk;
      if (k == ovr_at) begin wr_stb = 1'b1; wr_data = ~b; end else wr_stb = 1'b0;
      if (k == conf_at) conf_done = 1'b1;
      tick();
    end
    wr_stb = 1'b0;
    n_checks++;
    if (rises !== 8) begin
      n_fail++; $display("FAIL dclk_rises byte %02h: got %0d expected 8", b, rises);
    end
    n_checks++;
    if ({dclk, ready} !== {1'b0, !expect_init}) begin
      n_fail++; $display("FAIL byte_end dclk,ready: got %b expected %b", {dclk, ready}, {1'b0, !expect_init});
    end
  endtask

  task automatic test_reset();
    coldres_n = 1'b0; cfg_start = 1'b0; wr_stb = 1'b0; wr_data = 8'h00;
    status_n = 1'b1; conf_done = 1'b0; init_done = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({config_n, dclk, data0, ready, busy, done, error, overrun} !== 8'b1000_0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 10000000", {config_n, dclk, data0, ready, busy, done, error, overrun});
    end
    n_checks++;
    if ({t_config_n, t_dclk, t_data0, t_ready, t_busy, t_done, t_error, t_overrun} !== 8'b1000_0000) begin
      n_fail++; $display("FAIL reset_outputs_t: got %b expected 10000000", {t_config_n, t_dclk, t_data0, t_ready, t_busy, t_done, t_error, t_overrun});
    end
    coldres_n = 1'b1;
    tick();
  endtask

  task automatic test_ncfg();
    bring_up(20);
  endtask

  task automatic test_shift();
    send_byte(8'hA5, -1, -1, 1'b0);
    for (int i = 0; i < 2; i++) send_byte(8'($urandom), -1, -1, 1'b0);
  endtask

  task automatic test_initclk();
    logic [1:0] exp;
    int pulses;
    int n;
    int w;
    logic prev;
    bring_up($urandom_range(4, 30));
    send_byte(8'($urandom), -1, -1, 1'b0);
    send_byte(8'($urandom), -1, $urandom_range(0, 28), 1'b1);
    pulses = 0; prev = 1'b0;
    for (int j = 0; j < 2 * DIV * INITC; j++) begin
      exp = {((j % (2 * DIV)) >= DIV), 1'b1};
      n_checks++;
      if ({dclk, data0} !== exp) begin
        n_fail++; $display("FAIL initclk_trace cycle %0d: dclk,data0 got %b expected %b", j, {dclk, data0}, exp);
      end
      if (dclk === 1'b1 && prev === 1'b0) pulses++;
      prev = dclk;
      tick();
    end
    n_checks++;
    if (pulses !== INITC) begin
      n_fail++; $display("FAIL initclk_pulses: got %0d expected %0d", pulses, INITC);
    end
    w = $urandom_range(1, 5);
    for (int i = 0; i < w; i++) begin
      wr_stb = (i == 0);
      tick();
      n_checks++;
      if ({dclk, busy, done} !== 3'b010) begin
        n_fail++; $display("FAIL wait_init dclk,busy,done: got %b expected 010", {dclk, busy, done});
      end
    end
    wr_stb = 1'b0;
    init_done = 1'b1;
    n = 0;
    while (n < 10) begin
      n++; tick();
      if (done === 1'b1) break;
    end
    n_checks++;
    if (n !== 3) begin
      n_fail++; $display("FAIL done_latency: got %0d expected 3", n);
    end
    n_checks++;
    if ({busy, config_n, dclk, overrun, error} !== 5'b01000) begin
      n_fail++; $display("FAIL done_flags busy,config_n,dclk,overrun,error: got %b expected 01000", {busy, config_n, dclk, overrun, error});
    end
  endtask

  task automatic test_nstatus_fault();
    int n;
    status_n = 1'b1;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    n = 0;
    while (config_n === 1'b0 && n < 40) begin n++; tick(); end
    n_checks++;
    if (n !== NCFG) begin
      n_fail++; $display("FAIL nostatus_ncfg_len: got %0d expected %0d", n, NCFG);
    end
    n_checks++;
    if ({error, busy, ready} !== 3'b100) begin
      n_fail++; $display("FAIL nostatus_error error,busy,ready: got %b expected 100", {error, busy, ready});
    end
    status_n = 1'b0;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    n = 0;
    while (t_config_n === 1'b0 && n < 40) begin n++; tick(); end
    n = 0;
    while (t_error !== 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if (n !== 8) begin
      n_fail++; $display("FAIL st_timeout_cycles: got %0d expected 8", n);
    end
    n_checks++;
    if ({t_busy, t_ready, t_config_n} !== 3'b001) begin
      n_fail++; $display("FAIL st_timeout_flags busy,ready,config_n: got %b expected 001", {t_busy, t_ready, t_config_n});
    end
    status_n = 1'b1;
  endtask

  task automatic test_overrun_abort();
    int ab;
    int rises;
    bring_up($urandom_range(4, 30));
    send_byte(8'h3C, 5, -1, 1'b0);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    wr_data = 8'($urandom); wr_stb = 1'b1; tick(); wr_stb = 1'b0;
    ab = $urandom_range(3, 20);
    repeat (ab) tick();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    n_checks++;
    if ({dclk, config_n, overrun, ready, busy} !== 5'b00001) begin
      n_fail++; $display("FAIL abort dclk,config_n,overrun,ready,busy: got %b expected 00001", {dclk, config_n, overrun, ready, busy});
    end
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dclk !== 1'b0) rises++;
    end
    n_checks++;
    if (rises !== 0) begin
      n_fail++; $display("FAIL abort_no_dclk: got %0d high cycles expected 0", rises);
    end
  endtask

  task automatic test_status_fault_ready();
    int n;
    bring_up($urandom_range(4, 30));
    status_n = 1'b0;
    n = 0;
    while (n < 10) begin
      n++; tick();
      if (error === 1'b1) break;
    end
    n_checks++;
    if (n !== 3) begin
      n_fail++; $display("FAIL ready_fault_latency: got %0d expected 3", n);
    end
    n_checks++;
    if ({ready, busy} !== 2'b00) begin
      n_fail++; $display("FAIL ready_fault_flags ready,busy: got %b expected 00", {ready, busy});
    end
    status_n = 1'b1;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    n_checks++;
    if ({error, busy, done} !== 3'b010) begin
      n_fail++; $display("FAIL restart_clears error,busy,done: got %b expected 010", {error, busy, done});
    end
  endtask

  task automatic test_back_to_back();
    bring_up($urandom_range(4, 30));
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), -1, -1, 1'b0);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_ncfg();
    test_shift();
    test_initclk();
    test_nstatus_fault();
    test_overrun_abort();
    test_status_fault_ready();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
